// File: rtl/net_change_logger_pkg.sv
// +----------------------------------------------------------------------------+
// | ncl_pkg : shared types and sizing helpers for net_change_logger            |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

// One log entry; the parameters are given as macro arguments so a module with
// its own WIDTH/TS_W can declare a matching struct locally.
`ifndef NCL_ENTRY_T
`define NCL_ENTRY_T(W, T) struct packed { logic [(T)-1:0] stamp; logic [(W)-1:0] prev; logic [(W)-1:0] value; }
`endif

package ncl_pkg;

  localparam int NCL_WIDTH = 1;
  localparam int NCL_DEPTH = 4;
  localparam int NCL_TS_W  = 16;
  localparam int PTR_W     = $clog2(NCL_DEPTH);

  typedef `NCL_ENTRY_T(NCL_WIDTH, NCL_TS_W) ncl_entry_t;

  function automatic int ncl_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ncl_entry_w(input int width, input int ts_w);
    return ts_w + 2 * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/net_change_logger_fifo.sv
// +----------------------------------------------------------------------------+
// | ncl_event_fifo : synchronous FIFO with a registered head entry             |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ncl_event_fifo
  import ncl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = NCL_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = ncl_ptr_w(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] rd_nxt;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  assign level = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = head_q;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    head_d = head_q;
    rd_nxt = rd_q + PW'(1);

    if (push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + PW'(1);
    end

    // The head register must always mirror the oldest stored entry, so it is
    // refilled from the next slot on a pop, or straight from din when the
    // FIFO is (or is about to become) otherwise empty.
    if (pop) begin
      rd_d = rd_nxt;
      if (level > PW'(1)) begin
        head_d = mem_q[rd_nxt[AW-1:0]];
      end else if (push) begin
        head_d = din;
      end
    end else if (empty && push) begin
      head_d = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      mem_q  <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/net_change_logger.sv
// +----------------------------------------------------------------------------+
// | net_change_logger : clocked 4-state change detector feeding an event FIFO  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module net_change_logger
  import ncl_pkg::*;
#(
  parameter int WIDTH = NCL_WIDTH,
  parameter int DEPTH = NCL_DEPTH,
  parameter int TS_W  = NCL_TS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_value,
  output logic [WIDTH-1:0]         out_prev,
  output logic [TS_W-1:0]          out_stamp,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  typedef `NCL_ENTRY_T(WIDTH, TS_W) entry_t;
  localparam int EW = ncl_entry_w(WIDTH, TS_W);

  logic [TS_W-1:0]  stamp_q, stamp_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             primed_q, primed_d;
  logic             overflow_q, overflow_d;

  logic   evt;
  logic   pop;
  logic   push;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t din;
  entry_t head;

  always_comb begin
    stamp_d    = stamp_q + TS_W'(1);
    prev_d     = prev_q;
    primed_d   = primed_q;
    overflow_d = overflow_q;

    // 4-state compare so that x/z transitions count as changes.
    evt  = en && (!primed_q || (sample_in !== prev_q));
    pop  = !fifo_empty && out_ready;
    push = evt && (!fifo_full || pop);

    din.stamp = stamp_q;
    din.prev  = prev_q;
    din.value = sample_in;

    // prev tracks the true last sample even when its entry is dropped.
    if (evt) begin
      prev_d   = sample_in;
      primed_d = 1'b1;
      if (!push) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q    <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stamp_q    <= stamp_d;
      prev_q     <= prev_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
    end
  end

  ncl_event_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  assign out_value = head.value;
  assign out_prev  = head.prev;
  assign out_stamp = head.stamp;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_net_change_logger.sv
// +----------------------------------------------------------------------------+
// | tb_net_change_logger : directed self-checking bench for net_change_logger  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_net_change_logger;

  logic       clk;
  logic       rst;
  logic       en;
  logic       q;
  logic       out_ready;
  wire        sample_net;
  logic       out_valid;
  logic       out_value;
  logic       out_prev;
  logic [3:0] out_stamp;
  logic       overflow;
  logic [2:0] level;
  logic [5:0] head;
  logic [5:0] exp6;

  int total;
  int bad;

  // The observed signal is a continuously assigned net, not the reg itself.
  assign sample_net = q;
  assign head       = {out_stamp, out_prev, out_value};

  net_change_logger #(
    .WIDTH (1),
    .DEPTH (4),
    .TS_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample_in (sample_net),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_prev  (out_prev),
    .out_stamp (out_stamp),
    .overflow  (overflow),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with rst released; the next
  // edge is the first active one and carries stamp 0.
  task automatic do_reset;
    rst       = 1'b1;
    en        = 1'b0;
    q         = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (head !== 6'd0) begin bad++; $display("FAIL reset_head: got %b want 000000", head); end
  endtask

  task automatic test_first_sample;
    do_reset();
    en = 1'b1;
    q  = 1'b1;
    tick();
    exp6 = {4'd0, 1'b0, 1'b1};
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", out_valid); end
    total++; if (head !== exp6) begin bad++; $display("FAIL first_head: got %b want %b", head, exp6); end
    tick();
    tick();
    total++; if (level !== 3'd1) begin bad++; $display("FAIL first_level_held: got %0d want 1", level); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    en = 1'b1;
    q  = 1'b1;
    tick();
    q = 1'b0;
    tick();
    exp6 = {4'd0, 1'b0, 1'b1};
    total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_level: got %0d want 2", level); end
    total++; if (head !== exp6) begin bad++; $display("FAIL b2b_head0: got %b want %b", head, exp6); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp6 = {4'd1, 1'b1, 1'b0};
    total++; if (head !== exp6) begin bad++; $display("FAIL b2b_head1: got %b want %b", head, exp6); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL b2b_level_after_pop: got %0d want 1", level); end
  endtask

  // Expected entries come from a 4-state scoreboard over the driven values, so
  // x and z are changes wherever the simulator keeps them distinct.
  task automatic test_four_state;
    logic       v [5];
    logic       prevm;
    logic       primedm;
    logic [5:0] expq [$];
    v       = '{1'b0, 1'bx, 1'bz, 1'bz, 1'b0};
    prevm   = 1'b0;
    primedm = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q = v[i];
      tick();
      if (!primedm || (v[i] !== prevm)) begin
        expq.push_back({4'(i), prevm, v[i]});
        prevm   = v[i];
        primedm = 1'b1;
      end
    end
    en = 1'b0;
    total++; if (level !== 3'(expq.size())) begin bad++; $display("FAIL xz_level: got %0d want %0d", level, expq.size()); end
    for (int i = 0; i < expq.size(); i++) begin
      total++; if (head !== expq[i]) begin bad++; $display("FAIL xz_entry%0d: got %b want %b", i, head, expq[i]); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL xz_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_overflow;
    logic [5:0] kept [4];
    kept = '{{4'd0, 1'b0, 1'b0}, {4'd1, 1'b0, 1'b1}, {4'd2, 1'b1, 1'b0}, {4'd3, 1'b0, 1'b1}};
    do_reset();
    en = 1'b1;
    q  = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      q = ~q;
      tick();
    end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (head !== kept[i]) begin bad++; $display("FAIL ovf_kept%0d: got %b want %b", i, head, kept[i]); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    // Last sample was 0 (6th toggle); a 1 must log prev=0 at edge 11.
    en = 1'b1;
    q  = 1'b1;
    tick();
    en   = 1'b0;
    exp6 = {4'd11, 1'b0, 1'b1};
    total++; if (head !== exp6) begin bad++; $display("FAIL ovf_after_drain: got %b want %b", head, exp6); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop;
    logic [5:0] rest [3];
    rest = '{{4'd2, 1'b1, 1'b0}, {4'd3, 1'b0, 1'b1}, {4'd4, 1'b1, 1'b0}};
    do_reset();
    en = 1'b1;
    q  = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      q = ~q;
      tick();
    end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fp_full: got %0d want 4", level); end
    q         = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    en        = 1'b0;
    exp6      = {4'd1, 1'b0, 1'b1};
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fp_level: got %0d want 4", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow: got %b want 0", overflow); end
    total++; if (head !== exp6) begin bad++; $display("FAIL fp_head: got %b want %b", head, exp6); end
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (head !== rest[i]) begin bad++; $display("FAIL fp_rest%0d: got %b want %b", i, head, rest[i]); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset;
    do_reset();
    q = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    en = 1'b1;
    tick();
    tick();
    tick();
    q = 1'b0;
    tick();
    exp6 = {4'd14, 1'b0, 1'b1};
    total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_level: got %0d want 2", level); end
    total++; if (head !== exp6) begin bad++; $display("FAIL wrap_head14: got %b want %b", head, exp6); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp6      = {4'd1, 1'b1, 1'b0};
    total++; if (head !== exp6) begin bad++; $display("FAIL wrap_head1: got %b want %b", head, exp6); end
    for (int i = 0; i < 4; i++) begin
      q = ~q;
      tick();
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL wrap_overflow: got %b want 1", overflow); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (level !== 3'd3) begin bad++; $display("FAIL wrap_middrain: got %0d want 3", level); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL arst_level: got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL arst_overflow: got %b want 0", overflow); end
    total++; if (head !== 6'd0) begin bad++; $display("FAIL arst_head: got %b want 000000", head); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    en        = 1'b0;
    q         = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_first_sample();
    test_back_to_back();
    test_four_state();
    test_overflow();
    test_full_pop();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
